// File: rtl/w5500_spi_pkg.sv
// w5500_spi_pkg: shared types and field layout for the W5500 SPI slave.
// Control byte = {BSB[4:0], RW, OM[1:0]}; 16-bit address, 8-bit data.
package w5500_spi_pkg;

  localparam int AW = 16;
  localparam int DW = 8;

  localparam int BSB_HI = 7;
  localparam int BSB_LO = 3;
  localparam int RW_BIT = 2;
  localparam int OM_HI  = 1;
  localparam int OM_LO  = 0;

  localparam logic [1:0] OM_VDM  = 2'b00;
  localparam logic [1:0] OM_FDM1 = 2'b01;
  localparam logic [1:0] OM_FDM2 = 2'b10;
  localparam logic [1:0] OM_FDM4 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CTRL,
    WR_DAT,
    RD_DAT,
    HOLD
  } state_t;

  // Index of the final data byte in a fixed-length frame
  function automatic logic [1:0] fdm_last(input logic [1:0] om);
    logic [1:0] r;
    r = 2'd3;
    unique case (om)
      OM_FDM1: r = 2'd0;
      OM_FDM2: r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/w5500_spi_sync.sv
// w5500_spi_sync: multi-flop synchronizer with one history flop.
// Produces the synchronized level plus single-cycle rise/fall pulses.
module w5500_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   hist;

  // Synchronizer chain followed by the edge-detect history flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= {SYNC_STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], d};
      hist <= sr[SYNC_STAGES-1];
    end
  end

  assign q    = sr[SYNC_STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/w5500_spi_slv.sv
// w5500_spi_slv: SPI mode-0 slave terminating W5500 frames (addr/ctrl/data).
// Define W5500_SPI_SLV_FDM_EN to honour fixed-length (OM) frames.
module w5500_spi_slv
  import w5500_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        o_spi_miso,
  output logic        o_wr_en,
  output logic [15:0] o_wr_addr,
  output logic [4:0]  o_wr_bsb,
  output logic [7:0]  o_wr_dat,
  output logic        o_rd_req,
  output logic [15:0] o_rd_addr,
  output logic [4:0]  o_rd_bsb,
  input  logic [7:0]  rd_dat,
  output logic        o_frm_end,
  output logic        o_busy
);

  localparam logic [3:0] RW_CNT = 4'(7 - RW_BIT);
  localparam int         BW     = BSB_HI - BSB_LO + 1;

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  w5500_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  w5500_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .d(spi_sck),
    .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  w5500_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_s, sck_fall, mosi_rise, mosi_fall};

  state_t          state, state_nxt;
  logic [3:0]      bit_cnt;
  logic [AW-1:0]   addr;
  logic [BW-1:0]   bsb;
  logic            rd_q;
  logic [DW-1:0]   rx_sh, tx_sh, tx_buf;
  logic [RD_LAT:0] cap_pipe;
  logic            byte_end, last_byte;
  logic            addr_sh, ctrl_sh, wr_sh, rd_sh;
  logic            rw_smp, tx_load, pf_req, wr_fire, req_set;

  assign byte_end = (bit_cnt[2:0] == 3'd7);
  assign o_rd_req = cap_pipe[0];
  assign o_busy   = ~cs_s;

`ifdef W5500_SPI_SLV_FDM_EN
  logic [1:0] om_q, byte_cnt;

  // Latch the operating mode and count finished data bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      om_q     <= OM_VDM;
      byte_cnt <= '0;
    end else begin
      if (ctrl_sh && byte_end) om_q <= {rx_sh[0], mosi_s};
      if (state == IDLE) byte_cnt <= '0;
      else if ((wr_sh || rd_sh) && byte_end) byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign last_byte = (om_q != OM_VDM) && (byte_cnt == fdm_last(om_q));
`else
  assign last_byte = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; CS release always wins
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (cs_fall) state_nxt = ADDR;
      ADDR:   if (sck_rise && bit_cnt == 4'd15) state_nxt = CTRL;
      CTRL:   if (sck_rise && byte_end) state_nxt = rd_q ? RD_DAT : WR_DAT;
      WR_DAT: if (sck_rise && byte_end && last_byte) state_nxt = HOLD;
      RD_DAT: if (sck_rise && byte_end && last_byte) state_nxt = HOLD;
      default: ;
    endcase
    if (cs_rise && state != IDLE) state_nxt = IDLE;
  end

  // Per-cycle action decode from state and synchronized SCK
  always_comb begin
    addr_sh = 1'b0;
    ctrl_sh = 1'b0;
    wr_sh   = 1'b0;
    rd_sh   = 1'b0;
    if (sck_rise && !cs_rise) begin
      unique case (1'b1)
        state == ADDR:   addr_sh = 1'b1;
        state == CTRL:   ctrl_sh = 1'b1;
        state == WR_DAT: wr_sh   = 1'b1;
        state == RD_DAT: rd_sh   = 1'b1;
        default: ;
      endcase
    end
    rw_smp  = ctrl_sh && bit_cnt == RW_CNT;
    tx_load = byte_end && ((ctrl_sh && rd_q) || rd_sh);
    pf_req  = rd_sh && bit_cnt == 4'd0 && !last_byte;
    wr_fire = wr_sh && byte_end;
    req_set = (rw_smp && !mosi_s) || pf_req;
  end

  // Shift registers, address tracking, strobes and MISO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      addr       <= '0;
      bsb        <= '0;
      rd_q       <= 1'b0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      tx_buf     <= '0;
      cap_pipe   <= '0;
      o_spi_miso <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_bsb   <= '0;
      o_wr_dat   <= '0;
      o_rd_addr  <= '0;
      o_rd_bsb   <= '0;
      o_frm_end  <= 1'b0;
    end else begin
      o_wr_en   <= wr_fire;
      o_frm_end <= cs_rise && state != IDLE;
      cap_pipe  <= cs_rise ? '0 : {cap_pipe[RD_LAT-1:0], req_set};
      if (cap_pipe[RD_LAT] && !cs_rise) tx_buf <= rd_dat;

      if (state == IDLE) bit_cnt <= '0;
      else if (addr_sh) bit_cnt <= bit_cnt + 4'd1;
      else if (ctrl_sh || wr_sh || rd_sh)
        bit_cnt <= {1'b0, bit_cnt[2:0] + 3'd1};

      if (addr_sh) addr <= {addr[AW-2:0], mosi_s};
      if (ctrl_sh || wr_sh) rx_sh <= {rx_sh[DW-2:0], mosi_s};

      if (rw_smp) begin
        rd_q <= !mosi_s;
        bsb  <= rx_sh[BW-1:0];
        if (!mosi_s) begin
          o_rd_addr <= addr;
          o_rd_bsb  <= rx_sh[BW-1:0];
        end
      end

      if (rd_sh && bit_cnt == 4'd0) addr <= addr + 16'd1;
      if (pf_req) o_rd_addr <= addr + 16'd1;

      if (wr_fire) begin
        o_wr_addr <= addr;
        o_wr_bsb  <= bsb;
        o_wr_dat  <= {rx_sh[DW-2:0], mosi_s};
        addr      <= addr + 16'd1;
      end

      if (state_nxt != RD_DAT) begin
        o_spi_miso <= 1'b0;
      end else if (tx_load) begin
        o_spi_miso <= tx_buf[7];
        tx_sh      <= {tx_buf[6:0], 1'b0};
      end else if (rd_sh) begin
        o_spi_miso <= tx_sh[7];
        tx_sh      <= {tx_sh[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_w5500_spi_slv.sv
// tb_w5500_spi_slv: directed plus randomized W5500 frames against a
// frame-level model of expected write strobes, read requests and MISO bytes.
module tb_w5500_spi_slv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        o_spi_miso;
  logic        o_wr_en;
  logic [15:0] o_wr_addr;
  logic [4:0]  o_wr_bsb;
  logic [7:0]  o_wr_dat;
  logic        o_rd_req;
  logic [15:0] o_rd_addr;
  logic [4:0]  o_rd_bsb;
  logic [7:0]  rd_dat = 8'h00;
  logic        o_frm_end;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [28:0] wq[$];
  logic [20:0] rq[$];
  int          frm_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  logic [7:0]  wbuf[8];
  logic [7:0]  rbuf[8];

  w5500_spi_slv #(.SYNC_STAGES(2), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .o_spi_miso(o_spi_miso),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_bsb(o_wr_bsb), .o_wr_dat(o_wr_dat),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .o_rd_bsb(o_rd_bsb), .rd_dat(rd_dat),
    .o_frm_end(o_frm_end), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Register-space content as seen by the master
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Fixed data length selected by the control byte, 0 = until CS rises
  function automatic int fdm_len(input logic [7:0] c);
    int r;
    r = 0;
`ifdef W5500_SPI_SLV_FDM_EN
    case (c[1:0])
      2'b01: r = 1;
      2'b10: r = 2;
      2'b11: r = 4;
      default: r = 0;
    endcase
`endif
    return r;
  endfunction

  // Observe strobes and serve read data exactly one cycle after a request
  always @(negedge clk) begin
    if (o_wr_en) wq.push_back({o_wr_addr, o_wr_bsb, o_wr_dat});
    if (o_rd_req) rq.push_back({o_rd_addr, o_rd_bsb});
    if (o_frm_end) frm_cnt++;
    rd_dat  = rd_pend ? rd_val : 8'($urandom);
    rd_pend = o_rd_req;
    rd_val  = mem(o_rd_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({o_spi_miso, o_wr_en, o_wr_addr, o_wr_bsb, o_wr_dat,
                    o_rd_req, o_rd_addr, o_rd_bsb, o_frm_end, o_busy}),
          64'd0);
  endtask

  task automatic xfer(input logic [7:0] b, input int nb, input int hp,
                      output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = b[i];
      wait_clk(hp);
      spi_sck = 1'b1;
      r[i] = o_spi_miso;
      wait_clk(hp);
      spi_sck = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [15:0] a, input logic [7:0] c,
                          input int n, input int cut, input int hp);
    logic [7:0] r;
    spi_cs = 1'b0;
    wait_clk(4);
    xfer(a[15:8], 8, hp, r);
    xfer(a[7:0], 8, hp, r);
    xfer(c, 8, hp, r);
    for (int i = 0; i < n; i++) begin
      xfer(wbuf[i], (i == n - 1) ? cut : 8, hp, r);
      rbuf[i] = r;
    end
    wait_clk(hp);
    spi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic run_check(input string tag, input logic [15:0] a,
                           input logic [7:0] c, input int n,
                           input int cut, input int hp);
    int full, len, ne;
    logic [15:0] ea;
    wq.delete();
    rq.delete();
    frm_cnt = 0;
    do_frame(a, c, n, cut, hp);
    full = (cut == 8) ? n : n - 1;
    len  = fdm_len(c);
    if (c[2]) begin
      ne = (len != 0 && len < full) ? len : full;
      check({tag, "_wr_cnt"}, 64'(wq.size()), 64'(ne));
      for (int i = 0; i < ne && i < wq.size(); i++) begin
        ea = 16'(a + 16'(i));
        check({tag, "_wr"}, 64'(wq[i]), 64'({ea, c[7:3], wbuf[i]}));
      end
      check({tag, "_rd_cnt"}, 64'(rq.size()), 64'd0);
    end else begin
      ne = (len != 0 && len < full + 1) ? len : full + 1;
      check({tag, "_rd_cnt"}, 64'(rq.size()), 64'(ne));
      for (int i = 0; i < ne && i < rq.size(); i++) begin
        ea = 16'(a + 16'(i));
        check({tag, "_rd_req"}, 64'(rq[i]), 64'({ea, c[7:3]}));
      end
      for (int i = 0; i < full; i++) begin
        ea = 16'(a + 16'(i));
        check({tag, "_miso"}, 64'(rbuf[i]),
              64'((len == 0 || i < len) ? mem(ea) : 8'h00));
      end
      check({tag, "_wr_cnt"}, 64'(wq.size()), 64'd0);
    end
    check({tag, "_frm_end"}, 64'(frm_cnt), 64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_miso_idle"}, 64'(o_spi_miso), 64'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rc;
    int          rn, rh;

    wait_clk(4);
    check_zero("reset");
    rst_n = 1'b1;
    wait_clk(6);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h5A;
    run_check("wr2", 16'h0010, 8'h04, 2, 8, 2);

    run_check("rd3", 16'h0020, 8'h08, 3, 8, 4);

    wbuf[0] = 8'h3C;
    wbuf[1] = 8'hF0;
    run_check("cut5", 16'h0100, 8'h04, 2, 5, 3);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    run_check("wrap", 16'hFFFF, 8'h04, 2, 8, 2);

    wq.delete();
    rq.delete();
    frm_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'($urandom);
      wait_clk(3);
      spi_sck = 1'b1;
      wait_clk(3);
      spi_sck = 1'b0;
    end
    wait_clk(6);
    check("idle_sck_wr", 64'(wq.size()), 64'd0);
    check("idle_sck_rd", 64'(rq.size()), 64'd0);
    check("idle_sck_frm", 64'(frm_cnt), 64'd0);

    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    run_check("fdm2", 16'h0200, 8'h06, 4, 8, 2);

    fork
      do_frame(16'h1234, 8'h00, 4, 8, 3);
      begin
        wait_clk(4 + 24 * 6 + 15);
        check("busy_mid", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        wait_clk(1);
        check_zero("rst_mid");
        rst_n = 1'b1;
      end
    join
    wait_clk(20);

    wbuf[0] = 8'hC3;
    run_check("post_rst", 16'h0456, 8'h0C, 1, 8, 3);

    for (int k = 0; k < 16; k++) begin
      ra = 16'($urandom);
      rc = 8'($urandom);
      rn = $urandom_range(1, 4);
      rh = $urandom_range(2, 4);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      run_check("rand", ra, rc, rn, 8, rh);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
